maze_game_ctrl: RTL and testbench
=================================

Name: maze_game_ctrl

Overview:
- Parametrised game controller for the raycaster. It sequences idle, start screen, play, won and lost.
- It holds a runtime-loadable goal table for NUM_MAPS maps with up to NUM_GOALS goals each.
- It runs the round countdown timer internally and supports any-order and ordered goal collection.
- It sits between the player-movement block, which supplies posX/posY, and the frame-buffer screen selector and HUD.

Parameters:
- POS_W, 16, width of the player and goal position words (fixed point).
- FRAC_BITS, 8, fractional bits. Tile compare uses bits [POS_W-1:FRAC_BITS] only.
- NUM_MAPS, 4, number of selectable maps/games.
- NUM_GOALS, 4, maximum goals per map.
- TICK_CYCLES, 65_000_000, clock cycles per timer second.
- ROUND_SECONDS, 120, round length loaded at play start.
- HOLD_SECONDS, 5, how long the won/lost screen is shown.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- game_en_in  input  1  game mode enable (switch). Low means plain raycasting.
- start_in  input  1  start button, debounced level. Rising edge detected internally.
- map_sel_in  input  $clog2(NUM_MAPS)  map/game selection
- ordered_in  input  1  1 = goals must be collected in index order
- posX_in, posY_in  input  POS_W each  player position
- goal_wr_en_in  input  1  goal table write strobe
- goal_wr_map_in  input  $clog2(NUM_MAPS)  target map
- goal_wr_idx_in  input  $clog2(NUM_GOALS)  goal slot
- goal_wr_x_in, goal_wr_y_in  input  POS_W each  goal position
- goal_cnt_wr_en_in  input  1  writes the goal count for goal_wr_map_in
- goal_cnt_in  input  $clog2(NUM_GOALS+1)  goal count
- screen_display  output  2  0 = maze, 1 = start, 2 = lost, 3 = won
- found_mask_out  output  NUM_GOALS  goals collected this round
- time_left_out  output  8  seconds remaining
- playing_out  output  1  high in PLAY
- goal_hit_out  output  1  one-cycle pulse per newly found goal

Behaviour:
- Reset: state IDLE, screen_display 0, found_mask 0, time_left 0, playing 0, goal_hit 0, prescaler 0. Goal table and counts are cleared to 0.
- Reset mid-round aborts immediately; no result screen is shown.
- IDLE: screen 0.
  - game_en_in=1 → START next cycle, screen 1.
- START: map_sel_in and ordered_in are sampled each cycle.
  - Rising edge of start_in → PLAY. On that transition: latch map and mode, found_mask←0, time_left←ROUND_SECONDS, prescaler←0, screen 0, playing 1.
- PLAY:
  - Prescaler counts 0..TICK_CYCLES-1. At wrap, time_left decrements.
  - Expiry occurs when time_left==1 and the prescaler wraps. On expiry, time_left←0 and the next state is LOST.
- Goal match: goal i matches when its tile X/Y equals the player tile X/Y, i < latched goal count, and found[i]=0.
  - Any-order mode: every matching goal is set in the same cycle.
  - Ordered mode: only goal index next_idx can be set. next_idx is the lowest-index unset goal.
  - found_mask updates one cycle after the position is presented. goal_hit pulses in that same cycle.
- Win: when found_mask covers all goals [0..count-1], state → WON the cycle after the final bit is set.
- Simultaneous events: if the final goal sets in the same cycle as expiry, WON takes priority.
- Goal count 0: the map is free-roam. Win is impossible; the round ends only on timer expiry.
- WON / LOST: screen 3 / 2, playing 0. found_mask and time_left are frozen.
  - The hold counter runs HOLD_SECONDS×TICK_CYCLES cycles, then the state goes to START (screen 1).
- game_en_in=0 in any state → IDLE next cycle, screen 0, playing 0.
- Table writes are accepted only in IDLE or START; writes in other states are ignored.
  - A count write greater than NUM_GOALS saturates to NUM_GOALS.
  - A write and a goal compare in the same cycle cannot conflict, because writes are blocked in PLAY.

Test Plan:
- Reset/enable: rst_in low mid-PLAY → all outputs reset values next clk. Release, game_en=1 → screen_display=1 one cycle later.
- Any-order win: map0 count 3, goals (1,2),(3,4),(5,6); TICK_CYCLES=10 in bench. Visit (5,6),(1,2),(3,4) with fractional bits nonzero → three goal_hit pulses, mask 100→101→111, screen 3 the next cycle.
- Ordered mode: same map, visit (3,4) first → no hit. Then (1,2),(3,4),(5,6) → mask grows in order, WON.
- Timeout: ROUND_SECONDS=3, no goals visited → time_left 3→2→1→0, LOST exactly at 3×TICK_CYCLES cycles after the start edge. After HOLD returns to START.
- Tie: final goal reached on the expiry cycle → WON, not LOST. Count-0 map → only LOST is reachable.
- Write gating: goal_wr_en during PLAY → table unchanged, verified in the next round. Count write 7 with NUM_GOALS=4 → stored as 4.

Source files
------------

// File: rtl/maze_game_ctrl.sv
// rtl/maze_game_ctrl.sv - raycaster game sequencer: goal table, round timer, goal matching, screen select
module maze_game_ctrl #(
  parameter int POS_W         = 16,
  parameter int FRAC_BITS     = 8,
  parameter int NUM_MAPS      = 4,
  parameter int NUM_GOALS     = 4,
  parameter int TICK_CYCLES   = 65_000_000,
  parameter int ROUND_SECONDS = 120,
  parameter int HOLD_SECONDS  = 5
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           game_en_in,
  input  logic                           start_in,
  input  logic [$clog2(NUM_MAPS)-1:0]    map_sel_in,
  input  logic                           ordered_in,
  input  logic [POS_W-1:0]               posX_in,
  input  logic [POS_W-1:0]               posY_in,
  input  logic                           goal_wr_en_in,
  input  logic [$clog2(NUM_MAPS)-1:0]    goal_wr_map_in,
  input  logic [$clog2(NUM_GOALS)-1:0]   goal_wr_idx_in,
  input  logic [POS_W-1:0]               goal_wr_x_in,
  input  logic [POS_W-1:0]               goal_wr_y_in,
  input  logic                           goal_cnt_wr_en_in,
  input  logic [$clog2(NUM_GOALS+1)-1:0] goal_cnt_in,
  output logic [1:0]                     screen_display,
  output logic [NUM_GOALS-1:0]           found_mask_out,
  output logic [7:0]                     time_left_out,
  output logic                           playing_out,
  output logic                           goal_hit_out
);

  localparam int MAP_W       = $clog2(NUM_MAPS);
  localparam int CNT_W       = $clog2(NUM_GOALS + 1);
  localparam int PS_W        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int HOLD_CYCLES = HOLD_SECONDS * TICK_CYCLES;
  localparam int HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_PLAY, S_WON, S_LOST} state_t;

  state_t state, state_nxt;

  logic [POS_W-1:0]  goal_x   [NUM_MAPS][NUM_GOALS];
  logic [POS_W-1:0]  goal_y   [NUM_MAPS][NUM_GOALS];
  logic [CNT_W-1:0]  goal_cnt [NUM_MAPS];

  logic              start_q;
  logic [MAP_W-1:0]  map_q;
  logic              ordered_q;
  logic [PS_W-1:0]   presc;
  logic [HOLD_W-1:0] hold_cnt;

  logic                 start_rise, start_go, wr_ok, tick, expire, hold_done;
  logic                 all_found, next_done;
  logic [CNT_W-1:0]     cur_cnt;
  logic [NUM_GOALS-1:0] valid, hit_raw, first_open, new_bits;

  assign start_rise = start_in & ~start_q;
  assign start_go   = (state == S_START) && game_en_in && start_rise;
  assign wr_ok      = (state == S_IDLE) || (state == S_START);
  assign tick       = (presc == PS_W'(TICK_CYCLES - 1));
  assign expire     = tick && (time_left_out == 8'd1);
  assign hold_done  = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  assign cur_cnt    = goal_cnt[map_q];

  // Ordered mode only admits the lowest-index goal still outstanding.
  always_comb begin
    logic open_seen;
    open_seen  = 1'b0;
    valid      = '0;
    hit_raw    = '0;
    first_open = '0;
    for (int i = 0; i < NUM_GOALS; i++) begin
      valid[i]   = (i < int'(cur_cnt));
      hit_raw[i] = valid[i] && !found_mask_out[i]
                   && (goal_x[map_q][i][POS_W-1:FRAC_BITS] == posX_in[POS_W-1:FRAC_BITS])
                   && (goal_y[map_q][i][POS_W-1:FRAC_BITS] == posY_in[POS_W-1:FRAC_BITS]);
      if (valid[i] && !found_mask_out[i] && !open_seen) begin
        first_open[i] = 1'b1;
        open_seen     = 1'b1;
      end
    end
    new_bits = ordered_q ? (hit_raw & first_open) : hit_raw;
  end

  assign all_found = (cur_cnt != '0) && ((found_mask_out & valid) == valid);
  assign next_done = (cur_cnt != '0) && (((found_mask_out | new_bits) & valid) == valid);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // A final goal landing on the expiry edge keeps PLAY one more cycle so WON follows.
  always_comb begin
    state_nxt = state;
    if (!game_en_in) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_START;
        S_START: if (start_rise) state_nxt = S_PLAY;
        S_PLAY: begin
          if (all_found)                  state_nxt = S_WON;
          else if (expire && !next_done)  state_nxt = S_LOST;
        end
        S_WON, S_LOST: if (hold_done) state_nxt = S_START;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    screen_display = 2'd0;
    case (state)
      S_START: screen_display = 2'd1;
      S_LOST:  screen_display = 2'd2;
      S_WON:   screen_display = 2'd3;
      default: screen_display = 2'd0;
    endcase
  end

  assign playing_out = (state == S_PLAY);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int m = 0; m < NUM_MAPS; m++) begin
        goal_cnt[m] <= '0;
        for (int g = 0; g < NUM_GOALS; g++) begin
          goal_x[m][g] <= '0;
          goal_y[m][g] <= '0;
        end
      end
    end else begin
      if (wr_ok && goal_wr_en_in) begin
        goal_x[goal_wr_map_in][goal_wr_idx_in] <= goal_wr_x_in;
        goal_y[goal_wr_map_in][goal_wr_idx_in] <= goal_wr_y_in;
      end
      if (wr_ok && goal_cnt_wr_en_in)
        goal_cnt[goal_wr_map_in] <= (goal_cnt_in > CNT_W'(NUM_GOALS)) ?
                                    CNT_W'(NUM_GOALS) : goal_cnt_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      start_q        <= 1'b0;
      map_q          <= '0;
      ordered_q      <= 1'b0;
      found_mask_out <= '0;
      time_left_out  <= '0;
      presc          <= '0;
      hold_cnt       <= '0;
      goal_hit_out   <= 1'b0;
    end else begin
      start_q      <= start_in;
      goal_hit_out <= 1'b0;
      if (start_go) begin
        map_q          <= map_sel_in;
        ordered_q      <= ordered_in;
        found_mask_out <= '0;
        time_left_out  <= 8'(ROUND_SECONDS);
        presc          <= '0;
      end else if (state == S_PLAY && game_en_in) begin
        presc <= tick ? '0 : presc + PS_W'(1);
        if (tick && time_left_out != 8'd0)
          time_left_out <= time_left_out - 8'd1;
        found_mask_out <= found_mask_out | new_bits;
        goal_hit_out   <= |new_bits;
      end
      if (state == S_WON || state == S_LOST) hold_cnt <= hold_cnt + HOLD_W'(1);
      else                                   hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_maze_game_ctrl.sv
// tb/tb_maze_game_ctrl.sv - directed self-checking bench for maze_game_ctrl
module tb_maze_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, game_en, start, ordered;
  logic [1:0]  map_sel;
  logic [15:0] pos_x, pos_y;
  logic        gw_en, gc_en;
  logic [1:0]  gw_map, gw_idx;
  logic [15:0] gw_x, gw_y;
  logic [2:0]  gc_val;
  logic [1:0]  screen;
  logic [3:0]  mask;
  logic [7:0]  time_left;
  logic        playing, hit;

  int errors = 0;
  int checks = 0;
  int n;

  maze_game_ctrl #(
    .POS_W(16), .FRAC_BITS(8), .NUM_MAPS(4), .NUM_GOALS(4),
    .TICK_CYCLES(10), .ROUND_SECONDS(3), .HOLD_SECONDS(2)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .game_en_in(game_en), .start_in(start),
    .map_sel_in(map_sel), .ordered_in(ordered), .posX_in(pos_x), .posY_in(pos_y),
    .goal_wr_en_in(gw_en), .goal_wr_map_in(gw_map), .goal_wr_idx_in(gw_idx),
    .goal_wr_x_in(gw_x), .goal_wr_y_in(gw_y), .goal_cnt_wr_en_in(gc_en),
    .goal_cnt_in(gc_val), .screen_display(screen), .found_mask_out(mask),
    .time_left_out(time_left), .playing_out(playing), .goal_hit_out(hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] tile(input int t, input int frac);
    return 16'(t * 256 + frac);
  endfunction

  task automatic go_to(input int tx, input int ty);
    pos_x = tile(tx, 8'h5A);
    pos_y = tile(ty, 8'hC3);
    step();
  endtask

  task automatic wr_goal(input int m, input int i, input int tx, input int ty);
    gw_en = 1'b1; gw_map = 2'(m); gw_idx = 2'(i);
    gw_x = tile(tx, 8'h11); gw_y = tile(ty, 8'hEE);
    step();
    gw_en = 1'b0;
  endtask

  task automatic wr_cnt(input int m, input int c);
    gc_en = 1'b1; gw_map = 2'(m); gc_val = 3'(c);
    step();
    gc_en = 1'b0;
  endtask

  task automatic begin_round(input int m, input logic ord);
    map_sel = 2'(m); ordered = ord; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_screen(input string tag, input logic [1:0] target);
    n = 0;
    while (screen !== target && n < 100) begin
      step();
      n++;
    end
    check(tag, screen, target);
  endtask

  task automatic wait_hold(input string tag, input logic [1:0] target);
    n = 1;
    while (screen === target && n < 100) begin
      step();
      if (screen === target) n++;
    end
    check({tag, "_len"}, n, 20);
    check({tag, "_back"}, screen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; game_en = 1'b0; start = 1'b0; ordered = 1'b0; map_sel = '0;
    pos_x = '0; pos_y = '0; gw_en = 1'b0; gc_en = 1'b0;
    gw_map = '0; gw_idx = '0; gw_x = '0; gw_y = '0; gc_val = '0;
    step(); step();
    check("rst_screen", screen, 0);
    check("rst_mask", mask, 0);
    check("rst_time", time_left, 0);
    check("rst_playing", playing, 0);
    check("rst_hit", hit, 0);
    rst_n = 1'b1;

    wr_goal(0, 0, 1, 2); wr_goal(0, 1, 3, 4); wr_goal(0, 2, 5, 6); wr_cnt(0, 3);
    wr_goal(1, 0, 1, 1); wr_goal(1, 1, 2, 2); wr_goal(1, 2, 3, 3); wr_goal(1, 3, 4, 4);
    wr_cnt(1, 7);
    check("idle_screen", screen, 0);
    game_en = 1'b1;
    step();
    check("en_start_screen", screen, 1);

    // any-order collection on map 0
    begin_round(0, 1'b0);
    check("a_playing", playing, 1);
    check("a_screen", screen, 0);
    check("a_time", time_left, 3);
    check("a_mask0", mask, 0);
    go_to(5, 6);
    check("a_mask1", mask, 4'b0100); check("a_hit1", hit, 1);
    go_to(1, 2);
    check("a_mask2", mask, 4'b0101); check("a_hit2", hit, 1);
    step();
    check("a_hit_pulse", hit, 0);
    go_to(3, 4);
    check("a_mask3", mask, 4'b0111); check("a_hit3", hit, 1);
    check("a_still_play", screen, 0);
    step();
    check("a_won", screen, 3);
    check("a_won_playing", playing, 0);
    check("a_frozen_time", time_left, 3);
    wait_hold("a_hold", 3);
    check("a_frozen_mask", mask, 4'b0111);

    // ordered collection on map 0
    begin_round(0, 1'b1);
    ordered = 1'b0;
    go_to(3, 4);
    check("b_skip_mask", mask, 0); check("b_skip_hit", hit, 0);
    go_to(1, 2);
    check("b_mask1", mask, 4'b0001);
    go_to(3, 4);
    check("b_mask2", mask, 4'b0011);
    go_to(5, 6);
    check("b_mask3", mask, 4'b0111);
    step();
    check("b_won", screen, 3);
    wait_hold("b_hold", 3);

    // timeout on count-0 map 2, standing on its all-zero goal tile
    pos_x = tile(0, 8'h40); pos_y = tile(0, 8'h40);
    begin_round(2, 1'b0);
    check("c_time3", time_left, 3);
    repeat (9) step();
    check("c_time3_hold", time_left, 3);
    step();
    check("c_time2", time_left, 2);
    repeat (10) step();
    check("c_time1", time_left, 1);
    repeat (9) step();
    check("c_pre_expiry", playing, 1);
    step();
    check("c_lost", screen, 2);
    check("c_time0", time_left, 0);
    check("c_mask", mask, 0);
    wait_hold("c_hold", 2);

    // table writes during PLAY must be ignored
    begin_round(3, 1'b0);
    wr_goal(3, 0, 7, 7);
    wr_cnt(3, 1);
    wr_goal(0, 0, 9, 9);
    go_to(7, 7);
    check("d_gated_hit", hit, 0);
    check("d_gated_mask", mask, 0);
    wait_screen("d_lost", 2);
    wait_hold("d_hold", 2);

    // final goal set on the expiry edge: WON wins
    begin_round(0, 1'b0);
    go_to(1, 2);
    check("e_slot0_kept", mask, 4'b0001);
    go_to(3, 4);
    check("e_mask2", mask, 4'b0011);
    pos_x = '0; pos_y = '0;
    repeat (27) step();
    check("e_time1", time_left, 1);
    go_to(5, 6);
    check("e_mask3", mask, 4'b0111);
    check("e_time0", time_left, 0);
    check("e_not_lost", screen, 0);
    step();
    check("e_won", screen, 3);
    wait_hold("e_hold", 3);

    // count write of 7 saturates to 4 goals on map 1
    begin_round(1, 1'b0);
    go_to(1, 1); go_to(2, 2); go_to(3, 3);
    check("f_mask3", mask, 4'b0111);
    step();
    check("f_not_won", screen, 0);
    go_to(4, 4);
    check("f_mask4", mask, 4'b1111);
    step();
    check("f_won", screen, 3);
    wait_hold("f_hold", 3);

    // asynchronous reset mid-round
    begin_round(0, 1'b0);
    step(); step();
    rst_n = 1'b0;
    #1;
    check("g_rst_screen", screen, 0);
    check("g_rst_playing", playing, 0);
    check("g_rst_time", time_left, 0);
    check("g_rst_mask", mask, 0);
    step();
    rst_n = 1'b1;
    step();
    check("g_restart", screen, 1);
    pos_x = tile(1, 8'h20); pos_y = tile(2, 8'h20);
    begin_round(0, 1'b0);
    step();
    check("g_table_cleared", mask, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
